// File: rtl/load_store_interface_pkg.sv
// Shared encodings for the phoeniX load/store memory initiator: bus state
// values, access sizes and the FSM states.
package load_store_interface_pkg;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } fsm_state_e;

  // Byte lanes touched by an access at offset 0; bit k is byte offset k.
  function automatic logic [3:0] size_to_lanes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_lanes = 4'b0001;
      SIZE_HALF: size_to_lanes = 4'b0011;
      default:   size_to_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_lane_aligner.sv
// Combinational lane math: beat masks and crossing detect, store data lane
// placement, and load data extraction with sign/zero extension.
module load_store_lane_aligner
  import load_store_interface_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [63:0] merge,
  output logic        crossing,
  output logic [3:0]  mask_beat1,
  output logic [3:0]  mask_beat2,
  output logic [63:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  lane_enable;
  logic [31:0] shifted;

  // lane_enable[k] is byte offset k across both beats; the bus mask is bit-reversed.
  assign lane_enable = {4'b0000, size_to_lanes(size)} << offset;
  assign crossing    = |lane_enable[7:4];
  assign mask_beat1  = {lane_enable[0], lane_enable[1], lane_enable[2], lane_enable[3]};
  assign mask_beat2  = {lane_enable[4], lane_enable[5], lane_enable[6], lane_enable[7]};

  assign store_lanes = {32'b0, store_data} << {offset, 3'b000};
  assign shifted     = 32'(merge >> {offset, 3'b000});

  always_comb begin
    load_data = shifted;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = is_unsigned ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_interface.sv
// Core-side data memory initiator: one load/store at a time, word-crossing
// accesses split into two aligned beats, registered bus and response outputs.
module load_store_interface
  import load_store_interface_pkg::*;
#(
  parameter bit   SPLIT_MISALIGNED = 1'b1,
  parameter logic STATE_READ       = READ,
  parameter logic STATE_WRITE      = WRITE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [1:0]  request_size,
  input  logic        request_unsigned,
  input  logic [31:0] request_address,
  input  logic [31:0] request_store_data,
  output logic        response_valid,
  output logic [31:0] response_load_data,
  output logic        response_misaligned,
  output logic        memory_interface_enable,
  output logic        memory_interface_state,
  output logic [31:0] memory_interface_address,
  output logic [3:0]  memory_interface_frame_mask,
  inout  wire  [31:0] memory_interface_data
);

  fsm_state_e  state_q, state_n;
  logic [1:0]  offset_q, offset_n, size_q, size_n;
  logic        unsigned_q, unsigned_n, write_q, write_n, crossing_q, crossing_n;
  logic [63:0] lanes_q, lanes_n, merge_q, merge_n;
  logic [31:0] write_data_q, write_data_n;
  logic        enable_n, bus_state_n, resp_valid_n, resp_misaligned_n;
  logic [31:0] address_n, resp_data_n;
  logic [3:0]  mask_n;

  logic [1:0]  al_offset, al_size;
  logic        al_crossing;
  logic [3:0]  al_mask_beat1, al_mask_beat2;
  logic [63:0] al_store_lanes;
  logic [31:0] al_load_data;

  // The aligner sees the live request while idle and the latched access during beats.
  assign al_offset = (state_q == IDLE) ? request_address[1:0] : offset_q;
  assign al_size   = (state_q == IDLE) ? request_size : size_q;

  load_store_lane_aligner u_aligner (
    .offset      (al_offset),
    .size        (al_size),
    .is_unsigned (unsigned_q),
    .store_data  (request_store_data),
    .merge       (merge_n),
    .crossing    (al_crossing),
    .mask_beat1  (al_mask_beat1),
    .mask_beat2  (al_mask_beat2),
    .store_lanes (al_store_lanes),
    .load_data   (al_load_data)
  );

  assign request_ready         = (state_q == IDLE);
  assign memory_interface_data = (memory_interface_enable && memory_interface_state == STATE_WRITE)
                                 ? write_data_q : 'z;

  // Kept apart from the FSM block so the aligner's load path does not loop through it.
  always_comb begin
    merge_n = merge_q;
    case (state_q)
      BEAT1:   merge_n[31:0]  = memory_interface_data;
      BEAT2:   merge_n[63:32] = memory_interface_data;
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n           = state_q;
    offset_n          = offset_q;
    size_n            = size_q;
    unsigned_n        = unsigned_q;
    write_n           = write_q;
    crossing_n        = crossing_q;
    lanes_n           = lanes_q;
    write_data_n      = write_data_q;
    enable_n          = DISABLE;
    bus_state_n       = memory_interface_state;
    address_n         = memory_interface_address;
    mask_n            = 4'b0000;
    resp_valid_n      = 1'b0;
    resp_misaligned_n = 1'b0;
    resp_data_n       = response_load_data;

    case (state_q)
      IDLE: begin
        if (request_valid) begin
          offset_n   = request_address[1:0];
          size_n     = request_size;
          unsigned_n = request_unsigned;
          write_n    = request_write;
          crossing_n = al_crossing;
          lanes_n    = al_store_lanes;
          if (al_crossing && !SPLIT_MISALIGNED) begin
            resp_valid_n      = 1'b1;
            resp_misaligned_n = 1'b1;
            resp_data_n       = 32'b0;
          end else begin
            state_n      = BEAT1;
            enable_n     = ENABLE;
            bus_state_n  = request_write ? STATE_WRITE : STATE_READ;
            address_n    = {request_address[31:2], 2'b00};
            mask_n       = al_mask_beat1;
            write_data_n = al_store_lanes[31:0];
          end
        end
      end
      BEAT1: begin
        if (crossing_q) begin
          state_n      = BEAT2;
          enable_n     = ENABLE;
          address_n    = memory_interface_address + 32'd4;
          mask_n       = al_mask_beat2;
          write_data_n = lanes_q[63:32];
        end else begin
          state_n      = IDLE;
          resp_valid_n = 1'b1;
          resp_data_n  = write_q ? 32'b0 : al_load_data;
        end
      end
      BEAT2: begin
        state_n      = IDLE;
        resp_valid_n = 1'b1;
        resp_data_n  = write_q ? 32'b0 : al_load_data;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                     <= IDLE;
      offset_q                    <= 2'b00;
      size_q                      <= SIZE_BYTE;
      unsigned_q                  <= 1'b0;
      write_q                     <= 1'b0;
      crossing_q                  <= 1'b0;
      lanes_q                     <= 64'b0;
      merge_q                     <= 64'b0;
      write_data_q                <= 32'b0;
      memory_interface_enable     <= DISABLE;
      memory_interface_state      <= STATE_READ;
      memory_interface_address    <= 32'b0;
      memory_interface_frame_mask <= 4'b0000;
      response_valid              <= 1'b0;
      response_misaligned         <= 1'b0;
      response_load_data          <= 32'b0;
    end else begin
      state_q                     <= state_n;
      offset_q                    <= offset_n;
      size_q                      <= size_n;
      unsigned_q                  <= unsigned_n;
      write_q                     <= write_n;
      crossing_q                  <= crossing_n;
      lanes_q                     <= lanes_n;
      merge_q                     <= merge_n;
      write_data_q                <= write_data_n;
      memory_interface_enable     <= enable_n;
      memory_interface_state      <= bus_state_n;
      memory_interface_address    <= address_n;
      memory_interface_frame_mask <= mask_n;
      response_valid              <= resp_valid_n;
      response_misaligned         <= resp_misaligned_n;
      response_load_data          <= resp_data_n;
    end
  end

endmodule

// File: tb/tb_load_store_interface.sv
// Scoreboard bench: stimulus pushes expected beats/responses, monitors pop
// and compare; a word memory model answers bus beats.
module tb_load_store_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_store_data;
  logic        request_ready, response_valid, response_misaligned;
  logic [31:0] response_load_data;
  logic        mem_enable, mem_state;
  logic [31:0] mem_address;
  logic [3:0]  mem_mask;
  wire  [31:0] bus;
  logic        rd_oe;
  logic [31:0] rd_data;

  logic        n_valid, n_write, n_unsigned;
  logic [1:0]  n_size;
  logic [31:0] n_address, n_store_data;
  logic        n_ready, n_resp_valid, n_misaligned, n_enable, n_state;
  logic [31:0] n_load_data, n_mem_address;
  logic [3:0]  n_mask;
  wire  [31:0] n_bus;
  logic        n_en_seen = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (n_enable) n_en_seen <= 1'b1;

  assign bus = rd_oe ? rd_data : 'z;

  load_store_interface dut (
    .clk                         (clk),
    .reset                       (reset),
    .request_valid               (req_valid),
    .request_ready               (request_ready),
    .request_write               (req_write),
    .request_size                (req_size),
    .request_unsigned            (req_unsigned),
    .request_address             (req_address),
    .request_store_data          (req_store_data),
    .response_valid              (response_valid),
    .response_load_data          (response_load_data),
    .response_misaligned         (response_misaligned),
    .memory_interface_enable     (mem_enable),
    .memory_interface_state      (mem_state),
    .memory_interface_address    (mem_address),
    .memory_interface_frame_mask (mem_mask),
    .memory_interface_data       (bus)
  );

  load_store_interface #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
    .clk                         (clk),
    .reset                       (reset),
    .request_valid               (n_valid),
    .request_ready               (n_ready),
    .request_write               (n_write),
    .request_size                (n_size),
    .request_unsigned            (n_unsigned),
    .request_address             (n_address),
    .request_store_data          (n_store_data),
    .response_valid              (n_resp_valid),
    .response_load_data          (n_load_data),
    .response_misaligned         (n_misaligned),
    .memory_interface_enable     (n_enable),
    .memory_interface_state      (n_state),
    .memory_interface_address    (n_mem_address),
    .memory_interface_frame_mask (n_mask),
    .memory_interface_data       (n_bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: drives read data at negedge, releases and commits writes at posedge.
  initial begin
    rd_oe   = 1'b0;
    rd_data = 32'b0;
    forever begin
      @(negedge clk);
      if (!reset && mem_enable && mem_state == 1'b0) begin
        rd_data = mem.exists(mem_address) ? mem[mem_address] : 32'b0;
        rd_oe   = 1'b1;
      end
      @(posedge clk);
      if (!reset && mem_enable && mem_state == 1'b1) begin
        logic [31:0] w;
        w = mem.exists(mem_address) ? mem[mem_address] : 32'b0;
        for (int k = 0; k < 4; k++)
          if (mem_mask[3-k]) w[8*k +: 8] = bus[8*k +: 8];
        mem[mem_address] = w;
      end
      rd_oe <= 1'b0;
    end
  end

  // Monitor: compares every bus beat and every response against the queues.
  always @(negedge clk) begin : monitor
    beat_t b;
    resp_t r;
    if (!reset && mem_enable) begin
      if (beat_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
      else begin
        b = beat_q.pop_front();
        check("beat_state", {31'b0, mem_state}, {31'b0, b.wr});
        check("beat_address", mem_address, b.addr);
        check("beat_mask", {28'b0, mem_mask}, {28'b0, b.mask});
        if (b.wr) check("beat_data", bus, b.data);
      end
    end
    if (!reset && response_valid) begin
      if (resp_q.size() == 0) check("unexpected_response", 32'd1, 32'd0);
      else begin
        r = resp_q.pop_front();
        check("resp_data", response_load_data, r.data);
        check("resp_cycle", cyc, r.cyc);
        check("resp_misaligned", {31'b0, response_misaligned}, 32'd0);
        check("resp_ready", {31'b0, request_ready}, 32'd1);
      end
    end
  end

  task automatic exp_beat(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data);
    beat_q.push_back('{wr, addr, mask, data});
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input logic [31:0] exp_data);
    int waited = 0;
    @(negedge clk);
    while (!request_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {31'b0, request_ready}, 32'd1);
    req_valid      = 1'b1;
    req_write      = wr;
    req_size       = size;
    req_unsigned   = uns;
    req_address    = addr;
    req_store_data = data;
    resp_q.push_back('{exp_data, cyc + 1 + lat});
    @(posedge clk);
    #1;
    // Garbage on the request bus outside IDLE must be ignored.
    req_valid      = 1'b0;
    req_address    = 32'hDEAD_BEEF;
    req_store_data = 32'hCAFE_F00D;
    req_size       = 2'b00;
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_address = 32'b0; req_store_data = 32'b0;
    n_valid = 1'b0; n_write = 1'b0; n_size = 2'b00; n_unsigned = 1'b0;
    n_address = 32'b0; n_store_data = 32'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enable", {31'b0, mem_enable}, 32'd0);
    check("rst_address", mem_address, 32'd0);
    check("rst_mask", {28'b0, mem_mask}, 32'd0);
    check("rst_state", {31'b0, mem_state}, 32'd0);
    check("rst_resp_valid", {31'b0, response_valid}, 32'd0);
    check("rst_resp_data", response_load_data, 32'd0);
    check("rst_misaligned", {31'b0, response_misaligned}, 32'd0);
    check("rst_ready", {31'b0, request_ready}, 32'd1);
    reset = 1'b0;

    // Byte store, then signed/unsigned byte loads of the same lane.
    exp_beat(1'b1, 32'h100, 4'b0001, 32'hAB00_0000);
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB, 1, 32'h0);
    exp_beat(1'b0, 32'h100, 4'b0001, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'hFFFF_FFAB);
    exp_beat(1'b0, 32'h100, 4'b0001, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h0000_00AB);

    // Fill two words, then aligned, in-word and word-crossing loads.
    exp_beat(1'b1, 32'h100, 4'b1111, 32'h4433_2211);
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h4433_2211, 1, 32'h0);
    exp_beat(1'b1, 32'h104, 4'b1111, 32'h8877_6655);
    issue(1'b1, 2'b10, 1'b0, 32'h104, 32'h8877_6655, 1, 32'h0);
    exp_beat(1'b0, 32'h100, 4'b0011, 32'h0);
    exp_beat(1'b0, 32'h104, 4'b1100, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 2, 32'h6655_4433);
    exp_beat(1'b0, 32'h100, 4'b0110, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1, 32'h0000_3322);
    exp_beat(1'b0, 32'h100, 4'b0001, 32'h0);
    exp_beat(1'b0, 32'h104, 4'b1000, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 2, 32'h0000_5544);
    exp_beat(1'b0, 32'h104, 4'b0011, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 1, 32'hFFFF_8877);
    exp_beat(1'b0, 32'h104, 4'b0011, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 1, 32'h0000_8877);
    exp_beat(1'b0, 32'h104, 4'b1111, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 1, 32'h8877_6655);

    // Split store across the top of the address space, then read it back.
    exp_beat(1'b1, 32'hFFFF_FFFC, 4'b0001, 32'hAA00_0000);
    exp_beat(1'b1, 32'h0000_0000, 4'b1110, 32'h00DD_CCBB);
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'hDDCC_BBAA, 2, 32'h0);
    exp_beat(1'b0, 32'hFFFF_FFFC, 4'b0001, 32'h0);
    exp_beat(1'b0, 32'h0000_0000, 4'b1110, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 2, 32'hDDCC_BBAA);

    // Console address is an ordinary half store.
    exp_beat(1'b1, 32'h1000_0000, 4'b1100, 32'h0000_1234);
    issue(1'b1, 2'b01, 1'b0, 32'h1000_0000, 32'h0000_1234, 1, 32'h0);
    exp_beat(1'b0, 32'h1000_0000, 4'b1100, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h1000_0000, 32'h0, 1, 32'h0000_1234);

    // Non-splitting instance rejects a crossing half load without bus activity.
    @(negedge clk);
    n_valid = 1'b1; n_write = 1'b0; n_size = 2'b01; n_address = 32'h103;
    @(posedge clk);
    #1;
    n_valid = 1'b0;
    check("nosplit_resp_valid", {31'b0, n_resp_valid}, 32'd1);
    check("nosplit_misaligned", {31'b0, n_misaligned}, 32'd1);
    check("nosplit_enable", {31'b0, n_enable}, 32'd0);
    @(posedge clk);
    #1;
    check("nosplit_pulse_end", {31'b0, n_resp_valid}, 32'd0);

    // Reset during BEAT1 abandons the access without a response.
    waited = 0;
    @(negedge clk);
    while (!request_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_address = 32'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_mid_enable_before", {31'b0, mem_enable}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_enable_after", {31'b0, mem_enable}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_no_response", {31'b0, response_valid}, 32'd0);
    exp_beat(1'b0, 32'h104, 4'b1111, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1, 32'h8877_6655);

    waited = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("resp_queue_drained", resp_q.size(), 32'd0);
    check("beat_queue_drained", beat_q.size(), 32'd0);
    check("nosplit_never_enabled", {31'b0, n_en_seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_interface.md
Name: load_store_interface

Overview:
Core-side initiator for the phoeniX data memory interface. It drives enable, state, address, frame_mask and the bidirectional data bus toward an external memory responder. It accepts one load or store request at a time from the execute/memory stage. Accesses that cross a word boundary are split into two word-aligned bus beats, and load data is merged and sign- or zero-extended before it is returned to the pipeline.

Parameters:
SPLIT_MISALIGNED, 1, 1: split word-crossing accesses into two beats; 0: reject them with response_misaligned and no bus activity.
STATE_READ, 1'b0, value driven on memory_interface_state for reads (the codebase `READ define).
STATE_WRITE, 1'b1, value driven on memory_interface_state for writes (the codebase `WRITE define).

Ports:
clk  in  1  core clock.
reset  in  1  asynchronous, active-high reset.
request_valid  in  1  pipeline presents an access.
request_ready  out  1  block can accept a request; high only in IDLE.
request_write  in  1  1 = store, 0 = load.
request_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
request_unsigned  in  1  zero-extend the load result (LBU/LHU).
request_address  in  32  byte address.
request_store_data  in  32  store data, right-aligned.
response_valid  out  1  one-cycle completion pulse (loads and stores).
response_load_data  out  32  extended load result; 0 for stores.
response_misaligned  out  1  valid with response_valid; access was rejected.
memory_interface_enable  out  1  bus beat active.
memory_interface_state  out  1  STATE_READ / STATE_WRITE.
memory_interface_address  out  32  word-aligned address; bits [1:0] = 0.
memory_interface_frame_mask  out  4  byte lanes; mask[3-k] selects byte offset k (bits 8k+7:8k).
memory_interface_data  inout  32  driven only when enable && state == STATE_WRITE; otherwise 'z.

Behaviour:
- Reset (async): state IDLE; enable 0; address 0; mask 0; state = STATE_READ; response_valid 0; response_load_data 0; response_misaligned 0; data bus released to 'z.
- Reset asserted mid-beat: enable drops immediately, the beat is abandoned and no response is produced. A partial write may already have reached memory; this is acceptable.
- FSM states: IDLE, BEAT1, BEAT2. Outputs are registered.
- IDLE: request_ready = 1. On a posedge with request_valid:
  - latch offset = address[1:0], bytes = 1/2/4, and store_data << (8*offset) as a 64-bit lane vector;
  - crossing = offset + bytes > 4;
  - if crossing and SPLIT_MISALIGNED = 0: stay in IDLE and pulse response_valid + response_misaligned on the next cycle;
  - otherwise go to BEAT1.
- BEAT1 (one cycle):
  - enable = 1; address = request_address & ~3.
  - mask lanes = offset .. min(offset+bytes-1, 3).
  - Write data = lane vector [31:0].
  - At the closing posedge, read data is captured into merge[31:0]. The responder drives read data at negedge and clears it at posedge.
  - Next state is BEAT2 if crossing, else IDLE with response.
- BEAT2 (one cycle):
  - address = aligned address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - mask lanes = 0 .. offset+bytes-5.
  - Write data = lane vector [63:32]; read data is captured into merge[63:32].
  - Next state is IDLE with response.
- Response:
  - response_valid is high for exactly the one cycle after the final beat.
  - For loads, the raw value is ({merge} >> 8*offset) truncated to size, then sign- or zero-extended.
  - For stores, response_load_data = 0.
  - request_ready is high in the same cycle as response_valid, so back-to-back accepts are allowed.
- Latency from accept edge to response_valid: aligned 1 cycle, split 2 cycles. Peak throughput is one aligned access per 2 cycles.
- memory_interface_state is held stable for the whole beat. Read beats never drive the bus.
- Address 0x1000_0000 (console) gets no special treatment; it is a normal store.
- request_* inputs are ignored outside IDLE.

Decomposition:
- Shared header: size encodings, STATE_READ/STATE_WRITE, ENABLE/DISABLE, and the FSM state encodings.
- One sub-module, load_store_lane_aligner (combinational): offset/size to the two beat masks, the store lane vector, and the load extract/extend. The FSM stays in load_store_interface.

Test Plan:
1. SB 0xAB to 0x103 → one beat: address 0x100, mask 4'b0001, bus 0xAB000000; response_valid 1 cycle after accept.
2. mem[0x100] = 0xAB000000; LB 0x103 → 0xFFFFFFAB; LBU 0x103 → 0x000000AB; bus stays 'z during the reads.
3. mem[0x100] = 0x44332211, mem[0x104] = 0x88776655; LW 0x102 → beats at 0x100 (mask 4'b0011) then 0x104 (mask 4'b1100); result 0x66554433, response 2 cycles after accept.
4. SW 0xDDCCBBAA to 0xFFFFFFFF:
   - beat1: address 0xFFFFFFFC, mask 4'b0001, data 0xAA000000;
   - beat2: address 0x00000000, mask 4'b1110, data 0x00DDCCBB.
5. SPLIT_MISALIGNED = 0, LH 0x103 → enable never asserts; response_valid = 1 and response_misaligned = 1 on the next cycle.
6. Reset asserted during BEAT1 of LW 0x100 → enable 0 and bus 'z within the same cycle; no response_valid; after release, an LW to 0x104 completes normally.
